// File: rtl/biquad_cascade_sequencer.sv
// Sequences one sample through NUM_STAGES external biquad instances and owns
// the shadow/active coefficient and bypass banks.
module biquad_cascade_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic [15:0]                sample_in,
    input  logic                       coeff_wr_en,
    input  logic [2:0]                 coeff_wr_stage,
    input  logic [2:0]                 coeff_wr_sel,
    input  logic [15:0]                coeff_wr_data,
    input  logic                       bypass_wr_en,
    input  logic [NUM_STAGES-1:0]      bypass_wr_data,
    input  logic                       commit,
    input  logic                       clear_status,
    output logic [NUM_STAGES-1:0]      stage_start,
    output logic [15:0]                stage_data,
    output logic [NUM_STAGES*80-1:0]   stage_coeffs,
    input  logic [NUM_STAGES*16-1:0]   stage_result,
    input  logic [NUM_STAGES-1:0]      stage_done,
    output logic [15:0]                sample_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       commit_pending,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int KW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [KW-1:0]            k, k_nxt;
    logic [15:0]              cur, cur_nxt;
    logic [WW-1:0]            wait_cnt, wait_nxt;
    logic [15:0]              sample_out_nxt;
    logic                     pending_nxt, overrun_nxt, timeout_nxt;
    logic                     apply_commit, timeout_evt;
    logic [NUM_STAGES*80-1:0] shadow_coeffs, shadow_coeffs_nxt, active_coeffs;
    logic [NUM_STAGES-1:0]    shadow_bypass, shadow_bypass_nxt, active_bypass;
    logic                     sel_bypass, sel_done;
    logic [15:0]              sel_result;

    // Shadow next-value includes this cycle's write so a same-cycle commit picks it up.
    always_comb begin
        shadow_coeffs_nxt = shadow_coeffs;
        if (coeff_wr_en) begin
            for (int unsigned s = 0; s < NUM_STAGES; s++) begin
                for (int unsigned c = 0; c < 5; c++) begin
                    if (coeff_wr_stage == 3'(s) && coeff_wr_sel == 3'(c))
                        shadow_coeffs_nxt[80*s + 16*c +: 16] = coeff_wr_data;
                end
            end
        end
        shadow_bypass_nxt = bypass_wr_en ? bypass_wr_data : shadow_bypass;
    end

    always_comb begin
        sel_bypass = 1'b1;
        sel_done   = 1'b0;
        sel_result = '0;
        stage_start = '0;
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
            if (k == KW'(s)) begin
                sel_bypass = active_bypass[s];
                sel_done   = stage_done[s];
                sel_result = stage_result[16*s +: 16];
                stage_start[s] = (state == S_ISSUE) && !active_bypass[s];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        k_nxt          = k;
        cur_nxt        = cur;
        wait_nxt       = wait_cnt;
        sample_out_nxt = sample_out;
        apply_commit   = 1'b0;
        pending_nxt    = commit_pending | commit;
        timeout_evt    = 1'b0;
        case (state)
            S_IDLE: begin
                apply_commit = commit | commit_pending;
                pending_nxt  = 1'b0;
                if (sample_valid) begin
                    cur_nxt   = sample_in;
                    k_nxt     = '0;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_nxt = '0;
                if (!sel_bypass)
                    state_nxt = S_WAIT;
                else if (k == K_LAST)
                    state_nxt = S_DONE;
                else
                    k_nxt = k + KW'(1);
            end
            S_WAIT: begin
                if (sel_done) begin
                    cur_nxt = sel_result;
                    if (k == K_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        k_nxt     = k + KW'(1);
                        state_nxt = S_ISSUE;
                    end
                end else if (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_evt = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (state_nxt == S_DONE)
            sample_out_nxt = cur_nxt;
        overrun_nxt = (overrun & ~clear_status) | (sample_valid & (state != S_IDLE));
        timeout_nxt = (timeout_err & ~clear_status) | timeout_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            k              <= '0;
            cur            <= '0;
            wait_cnt       <= '0;
            sample_out     <= '0;
            commit_pending <= 1'b0;
            overrun        <= 1'b0;
            timeout_err    <= 1'b0;
            shadow_coeffs  <= '0;
            active_coeffs  <= '0;
            shadow_bypass  <= '1;
            active_bypass  <= '1;
        end else begin
            state          <= state_nxt;
            k              <= k_nxt;
            cur            <= cur_nxt;
            wait_cnt       <= wait_nxt;
            sample_out     <= sample_out_nxt;
            commit_pending <= pending_nxt;
            overrun        <= overrun_nxt;
            timeout_err    <= timeout_nxt;
            shadow_coeffs  <= shadow_coeffs_nxt;
            shadow_bypass  <= shadow_bypass_nxt;
            if (apply_commit) begin
                active_coeffs <= shadow_coeffs_nxt;
                active_bypass <= shadow_bypass_nxt;
            end
        end
    end

    assign stage_data   = (state == S_ISSUE && !sel_bypass) ? cur : '0;
    assign stage_coeffs = active_coeffs;
    assign out_valid    = (state == S_DONE);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_biquad_cascade_sequencer.sv
// Directed bench for biquad_cascade_sequencer with a behavioural stage model
// (fixed delay per stage, result = arithmetic x>>1, optional never-respond).
module tb_biquad_cascade_sequencer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sample_valid = 1'b0;
    logic [15:0]  sample_in = '0;
    logic         coeff_wr_en = 1'b0;
    logic [2:0]   coeff_wr_stage = '0;
    logic [2:0]   coeff_wr_sel = '0;
    logic [15:0]  coeff_wr_data = '0;
    logic         bypass_wr_en = 1'b0;
    logic [3:0]   bypass_wr_data = '0;
    logic         commit = 1'b0;
    logic         clear_status = 1'b0;
    logic [3:0]   stage_start;
    logic [15:0]  stage_data;
    logic [319:0] stage_coeffs;
    logic [63:0]  stage_result = '0;
    logic [3:0]   stage_done = '0;
    logic [15:0]  sample_out;
    logic         out_valid, busy, commit_pending, overrun, timeout_err;

    int checks = 0;
    int errors = 0;

    biquad_cascade_sequencer #(.NUM_STAGES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .coeff_wr_en(coeff_wr_en), .coeff_wr_stage(coeff_wr_stage), .coeff_wr_sel(coeff_wr_sel),
        .coeff_wr_data(coeff_wr_data), .bypass_wr_en(bypass_wr_en), .bypass_wr_data(bypass_wr_data),
        .commit(commit), .clear_status(clear_status), .stage_start(stage_start),
        .stage_data(stage_data), .stage_coeffs(stage_coeffs), .stage_result(stage_result),
        .stage_done(stage_done), .sample_out(sample_out), .out_valid(out_valid), .busy(busy),
        .commit_pending(commit_pending), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Stage model: done strobe exactly dly cycles after the start strobe.
    int          cyc = 0;
    int          dly[4] = '{1, 1, 1, 1};
    bit          never[4] = '{0, 0, 0, 0};
    bit          pend[4] = '{0, 0, 0, 0};
    int          due[4] = '{0, 0, 0, 0};
    logic [15:0] res[4] = '{16'h0, 16'h0, 16'h0, 16'h0};

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        stage_done = '0;
        if (reset) begin
            for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && cyc == due[i]) begin
                    stage_done[i] = 1'b1;
                    pend[i] = 1'b0;
                end
                if (stage_start[i]) begin
                    pend[i] = !never[i];
                    due[i]  = cyc + dly[i];
                    res[i]  = 16'($signed(stage_data) >>> 1);
                end
            end
        end
        stage_result = {res[3], res[2], res[1], res[0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coeff(input logic [2:0] st, input logic [2:0] sel, input logic [15:0] d);
        coeff_wr_en = 1'b1; coeff_wr_stage = st; coeff_wr_sel = sel; coeff_wr_data = d;
        tick();
        coeff_wr_en = 1'b0;
    endtask

    task automatic set_bypass_commit(input logic [3:0] m);
        bypass_wr_en = 1'b1; bypass_wr_data = m; commit = 1'b1;
        tick();
        bypass_wr_en = 1'b0; commit = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
    endtask

    // Drives one sample and observes until busy drops; cycle 1 is the cycle after acceptance.
    task automatic run_sample(input logic [15:0] x, input int budget, output int lat,
                              output int n_valid, output int end_c, output logic [3:0] starts,
                              output int first_start, output logic [15:0] y);
        lat = -1; n_valid = 0; end_c = -1; starts = '0; first_start = -1; y = '0;
        sample_in = x; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (stage_start != 4'b0 && first_start < 0) first_start = c;
            starts = starts | stage_start;
            if (out_valid) begin
                n_valid++;
                if (lat < 0) begin lat = c; y = sample_out; end
            end
            if (!busy) begin end_c = c; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if ({busy, out_valid, commit_pending, overrun, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, out_valid, commit_pending, overrun, timeout_err});
        end
        checks++;
        if (stage_start !== 4'b0 || stage_data !== 16'h0 || sample_out !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got start=%b data=%h out=%h expected 0/0/0",
                     stage_start, stage_data, sample_out);
        end
        checks++;
        if (stage_coeffs !== 320'h0) begin
            errors++;
            $display("FAIL reset_coeffs: got %h expected 0", stage_coeffs);
        end
    endtask

    task automatic test_passthrough();
        int lat, nv, endc, fs; logic [3:0] st; logic [15:0] y;
        run_sample(16'h1234, 40, lat, nv, endc, st, fs, y);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL pass_latency: got %0d expected 5", lat); end
        checks++;
        if (y !== 16'h1234) begin errors++; $display("FAIL pass_value: got %h expected 1234", y); end
        checks++;
        if (st !== 4'b0) begin errors++; $display("FAIL pass_no_start: got %b expected 0000", st); end
        checks++;
        if (nv !== 1 || endc !== 6) begin
            errors++;
            $display("FAIL pass_single_pulse: got pulses=%0d idle_at=%0d expected 1/6", nv, endc);
        end
    endtask

    task automatic test_coeff_commit();
        int lat, nv, endc, fs; logic [3:0] st; logic [15:0] y;
        logic [319:0] exp_c;
        exp_c = '0;
        exp_c[15:0] = 16'h7FFF;
        write_coeff(3'd0, 3'd0, 16'h7FFF);
        write_coeff(3'd4, 3'd0, 16'hAAAA);
        write_coeff(3'd1, 3'd5, 16'h5555);
        checks++;
        if (stage_coeffs !== 320'h0) begin
            errors++; $display("FAIL shadow_only: got %h expected 0", stage_coeffs);
        end
        dly[0] = 6;
        set_bypass_commit(4'b1110);
        checks++;
        if (stage_coeffs !== exp_c || commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL idle_commit: got %h pend=%b expected %h pend=0", stage_coeffs, commit_pending, exp_c);
        end
        run_sample(16'h1000, 40, lat, nv, endc, st, fs, y);
        checks++;
        if (fs !== 1 || st !== 4'b0001) begin
            errors++; $display("FAIL stage0_start: got cycle=%0d mask=%b expected 1/0001", fs, st);
        end
        checks++;
        if (lat !== 11 || y !== 16'h0800) begin
            errors++; $display("FAIL stage0_result: got lat=%0d y=%h expected 11/0800", lat, y);
        end
        run_sample(16'hE000, 40, lat, nv, endc, st, fs, y);
        checks++;
        if (lat !== 11 || y !== 16'hF000 || nv !== 1) begin
            errors++; $display("FAIL stage0_negative: got lat=%0d y=%h n=%0d expected 11/F000/1", lat, y, nv);
        end
    endtask

    task automatic test_commit_while_busy();
        logic [319:0] exp_old, exp_new;
        bit changed; int endc; logic [15:0] y;
        exp_old = '0; exp_old[15:0] = 16'h7FFF;
        exp_new = exp_old; exp_new[224 +: 16] = 16'h1357;
        changed = 1'b0; endc = -1; y = '0;
        sample_in = 16'h0400; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) begin
                checks++;
                if (commit_pending !== 1'b1) begin
                    errors++; $display("FAIL busy_commit_pending: got %b expected 1", commit_pending);
                end
            end
            if (stage_coeffs !== exp_old) changed = 1'b1;
            if (out_valid) y = sample_out;
            if (!busy) begin endc = c; break; end
            if (c == 2) begin
                coeff_wr_en = 1'b1; coeff_wr_stage = 3'd2; coeff_wr_sel = 3'd4;
                coeff_wr_data = 16'h1357; commit = 1'b1;
            end
            tick();
            coeff_wr_en = 1'b0; commit = 1'b0;
        end
        checks++;
        if (changed || endc !== 12 || y !== 16'h0200) begin
            errors++;
            $display("FAIL busy_coeffs_frozen: got changed=%0d idle_at=%0d y=%h expected 0/12/0200", changed, endc, y);
        end
        checks++;
        if (commit_pending !== 1'b1) begin
            errors++; $display("FAIL pending_first_idle: got %b expected 1", commit_pending);
        end
        tick();
        checks++;
        if (stage_coeffs !== exp_new || commit_pending !== 1'b0) begin
            errors++;
            $display("FAIL pending_applied: got %h pend=%b expected %h pend=0", stage_coeffs, commit_pending, exp_new);
        end
    endtask

    task automatic test_overrun();
        int nv, endc; logic [15:0] y;
        nv = 0; y = '0;
        sample_in = 16'h0100; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (out_valid) begin nv++; y = sample_out; end
            if (c == 3) begin sample_in = 16'h7777; sample_valid = 1'b1; end
            tick();
            sample_valid = 1'b0;
        end
        checks++;
        if (nv !== 1 || y !== 16'h0080) begin
            errors++; $display("FAIL overrun_drop: got pulses=%0d y=%h expected 1/0080", nv, y);
        end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        pulse_clear();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
        sample_in = 16'h0200; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        sample_valid = 1'b1; clear_status = 1'b1;
        tick();
        sample_valid = 1'b0; clear_status = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_event_wins: got %b expected 1", overrun);
        end
        endc = -1;
        for (int c = 0; c < 30; c++) begin
            if (!busy) begin endc = c; break; end
            tick();
        end
        checks++;
        if (endc < 0 || sample_out !== 16'h0100) begin
            errors++; $display("FAIL overrun_second_sample: got idle=%0d y=%h expected >=0/0100", endc, sample_out);
        end
        pulse_clear();
    endtask

    task automatic test_timeout();
        int lat, nv, endc, fs; logic [3:0] st; logic [15:0] y;
        dly[0] = 2;
        never[1] = 1'b1;
        set_bypass_commit(4'b1100);
        run_sample(16'h4000, 40, lat, nv, endc, st, fs, y);
        checks++;
        if (endc !== 21 || nv !== 0) begin
            errors++; $display("FAIL timeout_abort: got idle_at=%0d pulses=%0d expected 21/0", endc, nv);
        end
        checks++;
        if (timeout_err !== 1'b1 || sample_out !== 16'h0100) begin
            errors++; $display("FAIL timeout_flag: got err=%b out=%h expected 1/0100", timeout_err, sample_out);
        end
        never[1] = 1'b0;
        dly[1] = 16;
        run_sample(16'h0400, 40, lat, nv, endc, st, fs, y);
        checks++;
        if (lat !== 23 || y !== 16'h0100 || st !== 4'b0011) begin
            errors++; $display("FAIL done_at_limit: got lat=%0d y=%h starts=%b expected 23/0100/0011", lat, y, st);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
        end
        pulse_clear();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: got %b expected 0", timeout_err);
        end
        dly[1] = 3;
        run_sample(16'hF000, 40, lat, nv, endc, st, fs, y);
        checks++;
        if (lat !== 10 || y !== 16'hFC00) begin
            errors++; $display("FAIL after_timeout: got lat=%0d y=%h expected 10/FC00", lat, y);
        end
    endtask

    task automatic test_reset_mid_sample();
        int lat, nv, endc, fs; logic [3:0] st; logic [15:0] y;
        dly[2] = 8;
        set_bypass_commit(4'b1011);
        sample_in = 16'h0300; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin
                checks++;
                if (stage_start !== 4'b0100 || stage_data !== 16'h0300) begin
                    errors++;
                    $display("FAIL stage2_start: got %b data=%h expected 0100/0300", stage_start, stage_data);
                end
            end
            if (c == 4) begin bypass_wr_en = 1'b1; bypass_wr_data = 4'b0000; commit = 1'b1; end
            tick();
            bypass_wr_en = 1'b0; commit = 1'b0;
        end
        checks++;
        if (commit_pending !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_state: got pend=%b busy=%b expected 1/1", commit_pending, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, out_valid, commit_pending, overrun, timeout_err} !== 5'b0 ||
            stage_start !== 4'b0 || stage_data !== 16'h0 || sample_out !== 16'h0 ||
            stage_coeffs !== 320'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags=%b start=%b data=%h out=%h coeffs_nz=%b expected all 0",
                     {busy, out_valid, commit_pending, overrun, timeout_err}, stage_start,
                     stage_data, sample_out, |stage_coeffs);
        end
        run_sample(16'h1234, 40, lat, nv, endc, st, fs, y);
        checks++;
        if (lat !== 5 || y !== 16'h1234 || st !== 4'b0) begin
            errors++; $display("FAIL post_reset_bypass: got lat=%0d y=%h starts=%b expected 5/1234/0000", lat, y, st);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_coeff_commit();
        test_commit_while_busy();
        test_overrun();
        test_timeout();
        test_reset_mid_sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
